// File: rtl/vx_tcu_drl_excep_resolve.sv
// FEDP exception resolve: delays the issue-time exception summary to the datapath tail,
// overrides the raw result with canonical NaN/Inf and produces fflags. Optional sticky fflags: TCU_EXCEP_STICKY_EN.
module vx_tcu_drl_excep_resolve #(
    parameter int LATENCY = 4,
    parameter int TAG_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             exc_valid_in,
    input  logic [2:0]       exceptions_in,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             res_valid_in,
    input  logic [31:0]      res_in,
    input  logic             res_of_in,
    input  logic             res_uf_in,
    input  logic             res_nx_in,
    output logic             valid_out,
    output logic [31:0]      result_out,
    output logic [TAG_W-1:0] tag_out,
    output logic [4:0]       fflags_out,
    output logic [4:0]       sticky_fflags,
    input  logic             fflags_clear,
    output logic             desync_err
);
    // Entry layout: {valid, sign, is_nan, is_inf, tag}; exceptions_in is {sign, is_nan, is_inf}
    localparam int E_W   = TAG_W + 4;
    localparam int CNT_W = $clog2(LATENCY + 1);

    logic [E_W-1:0]   line_reg [LATENCY];
    logic [E_W-1:0]   tail;
    logic             tail_valid;
    logic             tail_sign;
    logic             tail_nan;
    logic             tail_inf;
    logic [TAG_W-1:0] tail_tag;

    logic             valid_next;
    logic [31:0]      result_next;
    logic [4:0]       fflags_next;

    logic [CNT_W-1:0] inflight_reg;
    logic [CNT_W-1:0] inflight_next;
    logic [CNT_W-1:0] occupancy;
    logic             capture;
    logic             consume;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) line_reg[i] <= '0;
        end else if (enable) begin
            line_reg[0] <= {exc_valid_in, exceptions_in, tag_in};
            for (int i = 1; i < LATENCY; i++) line_reg[i] <= line_reg[i-1];
        end
    end

    assign tail       = line_reg[LATENCY-1];
    assign tail_valid = tail[TAG_W+3];
    assign tail_sign  = tail[TAG_W+2];
    assign tail_nan   = tail[TAG_W+1];
    assign tail_inf   = tail[TAG_W];
    assign tail_tag   = tail[TAG_W-1:0];

    // NaN beats Inf beats the datapath result; DZ can never occur in a dot product
    always_comb begin
        valid_next  = res_valid_in & tail_valid;
        result_next = res_in;
        fflags_next = {2'b00, res_of_in, res_uf_in, res_nx_in};
        if (tail_nan) begin
            result_next = 32'h7FC0_0000;
            fflags_next = 5'b10000;
        end else if (tail_inf) begin
            result_next = tail_sign ? 32'hFF80_0000 : 32'h7F80_0000;
            fflags_next = 5'b00000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out  <= 1'b0;
            result_out <= '0;
            tag_out    <= '0;
            fflags_out <= '0;
        end else if (enable) begin
            valid_out  <= valid_next;
            result_out <= result_next;
            tag_out    <= tail_tag;
            fflags_out <= fflags_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            desync_err <= 1'b0;
        end else if (enable && (res_valid_in != tail_valid)) begin
            desync_err <= 1'b1;
        end
    end

`ifdef TCU_EXCEP_STICKY_EN
    // Clear takes effect first so a coinciding result leaves only its own flags
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_fflags <= '0;
        end else if (fflags_clear) begin
            sticky_fflags <= (enable && valid_next) ? fflags_next : 5'b00000;
        end else if (enable && valid_next) begin
            sticky_fflags <= sticky_fflags | fflags_next;
        end
    end
`else
    logic unused_clear;
    assign unused_clear  = fflags_clear;
    assign sticky_fflags = 5'b00000;
`endif

    // Occupancy bookkeeping; only observed by the checks below
    assign capture = enable & exc_valid_in;
    assign consume = enable & tail_valid;

    always_comb begin
        inflight_next = inflight_reg;
        if (capture && !consume && inflight_reg != CNT_W'(LATENCY)) begin
            inflight_next = inflight_reg + 1'b1;
        end else if (consume && !capture && inflight_reg != '0) begin
            inflight_next = inflight_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) inflight_reg <= '0;
        else       inflight_reg <= inflight_next;
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < LATENCY; i++) occupancy = occupancy + CNT_W'(line_reg[i][TAG_W+3]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (inflight_reg <= CNT_W'(LATENCY));
            assert (inflight_reg == occupancy);
        end
    end
endmodule

// File: tb/tb_vx_tcu_drl_excep_resolve.sv
// Directed bench for vx_tcu_drl_excep_resolve: vector table plus pipelined-freeze, desync and reset sequences.
module tb_vx_tcu_drl_excep_resolve;
    localparam int LATENCY = 4;
    localparam int TAG_W   = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             exc_valid_in;
    logic [2:0]       exceptions_in;
    logic [TAG_W-1:0] tag_in;
    logic             res_valid_in;
    logic [31:0]      res_in;
    logic             res_of_in;
    logic             res_uf_in;
    logic             res_nx_in;
    logic             valid_out;
    logic [31:0]      result_out;
    logic [TAG_W-1:0] tag_out;
    logic [4:0]       fflags_out;
    logic [4:0]       sticky_fflags;
    logic             fflags_clear;
    logic             desync_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vx_tcu_drl_excep_resolve #(.LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .exc_valid_in(exc_valid_in), .exceptions_in(exceptions_in), .tag_in(tag_in),
        .res_valid_in(res_valid_in), .res_in(res_in),
        .res_of_in(res_of_in), .res_uf_in(res_uf_in), .res_nx_in(res_nx_in),
        .valid_out(valid_out), .result_out(result_out), .tag_out(tag_out),
        .fflags_out(fflags_out), .sticky_fflags(sticky_fflags),
        .fflags_clear(fflags_clear), .desync_err(desync_err)
    );

    // exc = {sign, is_nan, is_inf}
    typedef struct {
        logic [2:0]  exc;
        logic [7:0]  tag;
        logic [31:0] res;
        logic        of;
        logic        uf;
        logic        nx;
        logic [31:0] exp_res;
        logic [4:0]  exp_ff;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        exc_valid_in  = 1'b0;
        exceptions_in = 3'b000;
        tag_in        = '0;
        res_valid_in  = 1'b0;
        res_in        = '0;
        res_of_in     = 1'b0;
        res_uf_in     = 1'b0;
        res_nx_in     = 1'b0;
        fflags_clear  = 1'b0;
    endtask

    task automatic run_vec(input int idx, input logic clr);
        vec_t v;
        v = vecs[idx];
        enable        = 1'b1;
        exc_valid_in  = 1'b1;
        exceptions_in = v.exc;
        tag_in        = v.tag;
        step();
        idle_inputs();
        step();
        chk("idle_valid", {31'd0, valid_out}, 32'd0);
        repeat (LATENCY - 2) step();
        res_valid_in = 1'b1;
        res_in       = v.res;
        res_of_in    = v.of;
        res_uf_in    = v.uf;
        res_nx_in    = v.nx;
        fflags_clear = clr;
        step();
        idle_inputs();
        chk("vec_valid",  {31'd0, valid_out}, 32'd1);
        chk("vec_result", result_out, v.exp_res);
        chk("vec_fflags", {27'd0, fflags_out}, {27'd0, v.exp_ff});
        chk("vec_tag",    {24'd0, tag_out}, {24'd0, v.tag});
        $display("vec %0d: exc=%b tag=%h res=%h -> result=%h fflags=%h", idx, v.exc, v.tag, v.res, result_out, fflags_out);
    endtask

    logic [7:0]  p_tag [3];
    logic [2:0]  p_exc [3];
    logic [31:0] p_res [3];
    logic        p_nx  [3];
    logic [31:0] p_exp [3];
    logic [4:0]  p_ff  [3];

    initial begin
        vecs[0] = '{3'b010, 8'h01, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 32'h7FC0_0000, 5'h10};
        vecs[1] = '{3'b111, 8'h02, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 32'h7FC0_0000, 5'h10};
        vecs[2] = '{3'b101, 8'h03, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'hFF80_0000, 5'h00};
        vecs[3] = '{3'b001, 8'h04, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h7F80_0000, 5'h00};
        vecs[4] = '{3'b000, 8'h05, 32'h7F7F_FFFF, 1'b1, 1'b0, 1'b1, 32'h7F7F_FFFF, 5'h05};
        vecs[5] = '{3'b000, 8'h06, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 32'h0000_0001, 5'h03};
        vecs[6] = '{3'b100, 8'h07, 32'hBF80_0000, 1'b0, 1'b0, 1'b0, 32'hBF80_0000, 5'h00};
        vecs[7] = '{3'b000, 8'h08, 32'h3F80_0001, 1'b0, 1'b0, 1'b1, 32'h3F80_0001, 5'h01};
        vecs[8] = '{3'b000, 8'h09, 32'h7F7F_FFFF, 1'b1, 1'b0, 1'b0, 32'h7F7F_FFFF, 5'h04};

        p_tag[0] = 8'hA1;  p_exc[0] = 3'b000; p_res[0] = 32'h1111_1111; p_nx[0] = 1'b1; p_exp[0] = 32'h1111_1111; p_ff[0] = 5'h01;
        p_tag[1] = 8'hB2;  p_exc[1] = 3'b010; p_res[1] = 32'h2222_2222; p_nx[1] = 1'b0; p_exp[1] = 32'h7FC0_0000; p_ff[1] = 5'h10;
        p_tag[2] = 8'hC3;  p_exc[2] = 3'b101; p_res[2] = 32'h3333_3333; p_nx[2] = 1'b0; p_exp[2] = 32'hFF80_0000; p_ff[2] = 5'h00;

        // Reset with enable low: reset must still win
        idle_inputs();
        enable = 1'b0;
        reset  = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        chk("rst_valid",  {31'd0, valid_out}, 32'd0);
        chk("rst_result", result_out, 32'd0);
        chk("rst_tag",    {24'd0, tag_out}, 32'd0);
        chk("rst_fflags", {27'd0, fflags_out}, 32'd0);
        chk("rst_sticky", {27'd0, sticky_fflags}, 32'd0);
        chk("rst_desync", {31'd0, desync_err}, 32'd0);

        for (int i = 0; i < 9; i++) run_vec(i, 1'b0);
        chk("vec_desync", {31'd0, desync_err}, 32'd0);
`ifdef TCU_EXCEP_STICKY_EN
        chk("sticky_accum", {27'd0, sticky_fflags}, 32'h17);
        enable       = 1'b0;
        fflags_clear = 1'b1;
        step();
        fflags_clear = 1'b0;
        enable       = 1'b1;
        chk("sticky_clear_frozen", {27'd0, sticky_fflags}, 32'h00);
        run_vec(0, 1'b0);
        run_vec(7, 1'b0);
        chk("sticky_nan_nx", {27'd0, sticky_fflags}, 32'h11);
        run_vec(8, 1'b1);
        chk("sticky_clear_of", {27'd0, sticky_fflags}, 32'h04);
`else
        chk("sticky_off", {27'd0, sticky_fflags}, 32'h00);
`endif

        // A, B, C back-to-back with a 3-cycle freeze while A is at the output
        begin
            int k;
            logic        ev;
            logic [31:0] er;
            logic [7:0]  et;
            logic [4:0]  ef;
            k  = 0;
            ev = 1'b0;
            er = '0;
            et = '0;
            ef = '0;
            for (int cyc = 0; k < 8; cyc++) begin
                enable = !(cyc >= 5 && cyc <= 7);
                idle_inputs();
                if (enable) begin
                    if (k < 3) begin
                        exc_valid_in  = 1'b1;
                        exceptions_in = p_exc[k];
                        tag_in        = p_tag[k];
                    end
                    if (k >= 4 && k <= 6) begin
                        res_valid_in = 1'b1;
                        res_in       = p_res[k-4];
                        res_nx_in    = p_nx[k-4];
                    end
                end else begin
                    exc_valid_in  = 1'b1;
                    exceptions_in = 3'b010;
                    tag_in        = 8'hEE;
                    res_valid_in  = 1'b1;
                    res_in        = 32'hDEAD_BEEF;
                    res_of_in     = 1'b1;
                end
                step();
                if (enable) begin
                    ev = (k >= 4 && k <= 6);
                    if (ev) begin
                        er = p_exp[k-4];
                        et = p_tag[k-4];
                        ef = p_ff[k-4];
                    end
                    k++;
                end
                chk("pipe_valid", {31'd0, valid_out}, {31'd0, ev});
                if (ev) begin
                    chk("pipe_result", result_out, er);
                    chk("pipe_tag",    {24'd0, tag_out}, {24'd0, et});
                    chk("pipe_fflags", {27'd0, fflags_out}, {27'd0, ef});
                end
                $display("pipe cyc %0d: en=%0b valid=%0b tag=%h result=%h", cyc, enable, valid_out, tag_out, result_out);
            end
            idle_inputs();
            enable = 1'b1;
            chk("pipe_desync", {31'd0, desync_err}, 32'd0);
        end

        // Result with empty tail: desync is sticky until reset
        res_valid_in = 1'b1;
        res_in       = 32'h4040_0000;
        step();
        idle_inputs();
        chk("desync_valid", {31'd0, valid_out}, 32'd0);
        chk("desync_set",   {31'd0, desync_err}, 32'd1);
        repeat (3) step();
        chk("desync_hold",  {31'd0, desync_err}, 32'd1);
        $display("desync: valid=%0b desync_err=%0b", valid_out, desync_err);

        // Reset with an entry in flight must empty the line
        exc_valid_in  = 1'b1;
        exceptions_in = 3'b010;
        tag_in        = 8'h5A;
        step();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_desync", {31'd0, desync_err}, 32'd0);
        chk("rst2_valid",  {31'd0, valid_out}, 32'd0);
        repeat (LATENCY + 1) step();
        chk("rst2_empty",  {31'd0, desync_err}, 32'd0);
        $display("reset: desync_err=%0b valid=%0b", desync_err, valid_out);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
